mem_arbiter: RTL and testbench

- Shares one external memory port between the instruction-fetch requester and the data (M-stage) requester of the pipeline.
- Produces inst_mem_ack and data_mem_ack for the hazard unit, which holds stalls until they pulse.
- Fixed priority: data beats instruction, with a starvation guard for fetch.
- Multi-cycle memory handshake through mem_req/mem_ready.

---
 rtl/mem_arbiter_if.sv | 38 +++
 rtl/mem_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_arbiter.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the shared memory port and mem_arbiter.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface mem_arbiter_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        inst_mem_ack;
  logic        data_req;
  logic        data_we;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_byte_en;
  logic [31:0] data_rdata;
  logic        data_mem_ack;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byte_en;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        busy;
  logic        bus_err;

  modport slave (
    input  inst_req, inst_addr, data_req, data_we, data_addr, data_wdata, data_byte_en,
           mem_rdata, mem_ready,
    output inst_rdata, inst_mem_ack, data_rdata, data_mem_ack,
           mem_req, mem_we, mem_addr, mem_wdata, mem_byte_en, busy, bus_err
  );

  modport master (
    output inst_req, inst_addr, data_req, data_we, data_addr, data_wdata, data_byte_en,
           mem_rdata, mem_ready,
    input  inst_rdata, inst_mem_ack, data_rdata, data_mem_ack,
           mem_req, mem_we, mem_addr, mem_wdata, mem_byte_en, busy, bus_err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one memory port between fetch and data requesters; data has priority with a fetch starvation guard.
// Optional BUSY watchdog with sticky bus_err is enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter #(
  parameter int unsigned STARVE_MAX     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  localparam int unsigned CW = ($clog2(STARVE_MAX + 1) > 3) ? $clog2(STARVE_MAX + 1) : 3;
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

  state_t        state, state_nx;
  logic          grant_data;
  logic          r_we;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [3:0]    r_be;
  logic [31:0]   inst_rdata_q;
  logic [31:0]   data_rdata_q;
  logic [CW-1:0] starve_cnt;
  logic          data_win;
  logic          inst_win;
  logic          tmo_hit;
  logic          busy_done;
  logic [31:0]   cap_data;

  always_comb begin
    state_nx          = state;
    data_win          = bus.data_req && !(bus.inst_req && (starve_cnt == STARVE_LIM));
    inst_win          = bus.inst_req && !data_win;
    busy_done         = bus.mem_ready || tmo_hit;
    cap_data          = bus.mem_ready ? bus.mem_rdata : 32'hDEAD_BEEF;
    bus.mem_req       = 1'b0;
    bus.mem_we        = 1'b0;
    bus.inst_mem_ack  = 1'b0;
    bus.data_mem_ack  = 1'b0;
    bus.busy          = (state != IDLE);
    unique case (state)
      IDLE: if (data_win || inst_win) state_nx = BUSY;
      BUSY: begin
        bus.mem_req = 1'b1;
        bus.mem_we  = r_we;
        if (busy_done) state_nx = ACK;
      end
      ACK: begin
        bus.inst_mem_ack = !grant_data;
        bus.data_mem_ack = grant_data;
        state_nx         = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.mem_addr    = r_addr;
  assign bus.mem_wdata   = r_wdata;
  assign bus.mem_byte_en = r_be;
  assign bus.inst_rdata  = inst_rdata_q;
  assign bus.data_rdata  = data_rdata_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      grant_data   <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_be         <= '0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
      starve_cnt   <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE) begin
        if (data_win) begin
          grant_data <= 1'b1;
          r_we       <= bus.data_we;
          r_addr     <= bus.data_addr;
          r_wdata    <= bus.data_wdata;
          r_be       <= bus.data_byte_en;
          if (!bus.inst_req) starve_cnt <= '0;
          else if (starve_cnt != STARVE_LIM) starve_cnt <= starve_cnt + 1'b1;
        end else if (inst_win) begin
          grant_data <= 1'b0;
          r_we       <= 1'b0;
          r_addr     <= bus.inst_addr;
          r_wdata    <= '0;
          r_be       <= '1;
          starve_cnt <= '0;
        end
      end
      // A completed write leaves data_rdata alone; an abandoned access always reports the poison word.
      if (state == BUSY && busy_done) begin
        if (!grant_data) inst_rdata_q <= cap_data;
        else if (!r_we || !bus.mem_ready) data_rdata_q <= cap_data;
      end
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned TW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tmo_cnt;
  logic          bus_err_q;

  assign tmo_hit     = (state == BUSY) && !bus.mem_ready && (tmo_cnt == TMO_LAST);
  assign bus.bus_err = bus_err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt   <= '0;
      bus_err_q <= 1'b0;
    end else begin
      tmo_cnt <= (state == BUSY) ? tmo_cnt + 1'b1 : '0;
      if (tmo_hit) bus_err_q <= 1'b1;
    end
  end
`else
  assign tmo_hit     = 1'b0;
  assign bus.bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: reset, fetch, contention, starvation, slow memory, timeout.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  mem_arbiter_if bus ();

  mem_arbiter #(.STARVE_MAX(4), .TIMEOUT_CYCLES(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [1:0] seq [6];
    logic [1:0] exp_seq [6];
    int unsigned n_ack;
    int unsigned n_busy;
    logic ack_seen;

    bus.inst_req = 0; bus.inst_addr = '0;
    bus.data_req = 0; bus.data_we = 0; bus.data_addr = '0; bus.data_wdata = '0; bus.data_byte_en = '0;
    bus.mem_rdata = '0; bus.mem_ready = 0;
    tick(); tick();
    chk("rst_mem_req", 32'(bus.mem_req), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_acks", 32'({bus.inst_mem_ack, bus.data_mem_ack}), 0);
    chk("rst_inst_rdata", bus.inst_rdata, 0);
    chk("rst_data_rdata", bus.data_rdata, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_bus_err", 32'(bus.bus_err), 0);
    reset = 1;
    tick();

    // reset in the middle of a fetch
    bus.inst_req = 1; bus.inst_addr = 32'h0000_0100;
    tick();
    chk("mid_mem_req", 32'(bus.mem_req), 1);
    chk("mid_mem_addr", bus.mem_addr, 32'h0000_0100);
    tick();
    reset = 0;
    #1;
    chk("mid_rst_mem_req", 32'(bus.mem_req), 0);
    chk("mid_rst_busy", 32'(bus.busy), 0);
    chk("mid_rst_ack", 32'(bus.inst_mem_ack), 0);
    bus.inst_req = 0;
    tick();
    reset = 1;
    tick();
    chk("mid_post_busy", 32'(bus.busy), 0);
    chk("mid_post_ack", 32'(bus.inst_mem_ack), 0);

    // single fetch with zero-wait memory
    bus.inst_req = 1; bus.inst_addr = 32'h0040_0000;
    bus.mem_ready = 1; bus.mem_rdata = 32'h2408_0005;
    tick();
    chk("f_mem_req", 32'(bus.mem_req), 1);
    chk("f_mem_addr", bus.mem_addr, 32'h0040_0000);
    chk("f_mem_be", 32'(bus.mem_byte_en), 32'hF);
    chk("f_mem_we", 32'(bus.mem_we), 0);
    chk("f_early_ack", 32'(bus.inst_mem_ack), 0);
    tick();
    chk("f_ack", 32'(bus.inst_mem_ack), 1);
    chk("f_dack", 32'(bus.data_mem_ack), 0);
    chk("f_rdata", bus.inst_rdata, 32'h2408_0005);
    chk("f_ack_mem_req", 32'(bus.mem_req), 0);
    bus.inst_req = 0; bus.mem_ready = 0;
    tick();
    chk("f_ack_pulse", 32'(bus.inst_mem_ack), 0);
    chk("f_idle", 32'(bus.busy), 0);
    chk("f_rdata_hold", bus.inst_rdata, 32'h2408_0005);

    // simultaneous requests: data write first, fetch three cycles later
    bus.inst_req = 1; bus.inst_addr = 32'h0040_0004;
    bus.data_req = 1; bus.data_we = 1; bus.data_addr = 32'h1000_0004;
    bus.data_wdata = 32'hCAFE_F00D; bus.data_byte_en = 4'b0011;
    bus.mem_ready = 1; bus.mem_rdata = 32'h1111_1111;
    tick();
    chk("c_mem_we", 32'(bus.mem_we), 1);
    chk("c_mem_be", 32'(bus.mem_byte_en), 32'h3);
    chk("c_mem_addr", bus.mem_addr, 32'h1000_0004);
    chk("c_mem_wdata", bus.mem_wdata, 32'hCAFE_F00D);
    tick();
    chk("c_dack", 32'(bus.data_mem_ack), 1);
    chk("c_no_iack", 32'(bus.inst_mem_ack), 0);
    chk("c_wr_rdata", bus.data_rdata, 0);
    bus.data_req = 0; bus.data_we = 0;
    tick();
    chk("c_dack_pulse", 32'(bus.data_mem_ack), 0);
    chk("c_iack_early1", 32'(bus.inst_mem_ack), 0);
    tick();
    chk("c_f_addr", bus.mem_addr, 32'h0040_0004);
    chk("c_f_be", 32'(bus.mem_byte_en), 32'hF);
    chk("c_f_we", 32'(bus.mem_we), 0);
    tick();
    chk("c_iack", 32'(bus.inst_mem_ack), 1);
    chk("c_iack_rdata", bus.inst_rdata, 32'h1111_1111);
    bus.inst_req = 0; bus.mem_ready = 0;
    tick();

    // starvation guard: four data grants, then fetch, then data again
    exp_seq[0] = 2'b01; exp_seq[1] = 2'b01; exp_seq[2] = 2'b01;
    exp_seq[3] = 2'b01; exp_seq[4] = 2'b10; exp_seq[5] = 2'b01;
    for (int i = 0; i < 6; i++) seq[i] = 2'b00;
    n_ack = 0;
    bus.inst_req = 1; bus.inst_addr = 32'h0040_0008;
    bus.data_req = 1; bus.data_we = 0; bus.data_addr = 32'h2000_0000;
    bus.mem_ready = 1; bus.mem_rdata = 32'hA5A5_0000;
    for (int c = 0; c < 18; c++) begin
      tick();
      chk("s_ack_excl", 32'(bus.inst_mem_ack & bus.data_mem_ack), 0);
      if (bus.inst_mem_ack || bus.data_mem_ack) begin
        if (n_ack < 6) seq[n_ack] = {bus.inst_mem_ack, bus.data_mem_ack};
        n_ack++;
      end
    end
    bus.inst_req = 0; bus.data_req = 0; bus.mem_ready = 0;
    chk("s_n_ack", n_ack, 6);
    for (int i = 0; i < 6; i++) chk($sformatf("s_order%0d", i), 32'(seq[i]), 32'(exp_seq[i]));
    chk("s_data_rdata", bus.data_rdata, 32'hA5A5_0000);
    tick();
    chk("s_idle", 32'(bus.busy), 0);

    // slow memory: six BUSY cycles, requester changes ignored
    bus.data_req = 1; bus.data_we = 0; bus.data_addr = 32'h3000_0008; bus.data_byte_en = 4'hF;
    tick();
    bus.data_addr = 32'hFFFF_FFFF; bus.data_we = 1; bus.data_byte_en = 4'h0;
    for (int i = 0; i < 6; i++) begin
      chk("w_mem_req", 32'(bus.mem_req), 1);
      chk("w_mem_addr", bus.mem_addr, 32'h3000_0008);
      chk("w_mem_we", 32'(bus.mem_we), 0);
      if (i == 5) begin bus.mem_ready = 1; bus.mem_rdata = 32'h5555_AAAA; end
      tick();
    end
    chk("w_dack", 32'(bus.data_mem_ack), 1);
    chk("w_mem_req_off", 32'(bus.mem_req), 0);
    chk("w_rdata", bus.data_rdata, 32'h5555_AAAA);
    bus.data_req = 0; bus.data_we = 0; bus.mem_ready = 0;
    tick();

    // memory never answers
    bus.data_req = 1; bus.data_addr = 32'h4000_0000;
    tick();
    n_busy = 0;
    ack_seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.data_mem_ack) begin
        ack_seen = 1;
        break;
      end
      if (bus.mem_req) n_busy++;
      tick();
    end
`ifdef MEM_ARB_TIMEOUT_EN
    chk("t_ack_seen", 32'(ack_seen), 1);
    chk("t_busy_cycles", n_busy, 8);
    chk("t_rdata", bus.data_rdata, 32'hDEAD_BEEF);
    chk("t_bus_err", 32'(bus.bus_err), 1);
    bus.data_req = 0;
    tick(); tick(); tick();
    chk("t_bus_err_sticky", 32'(bus.bus_err), 1);
`else
    chk("t_no_ack", 32'(ack_seen), 0);
    chk("t_busy_cycles", n_busy, 20);
    chk("t_still_busy", 32'(bus.busy), 1);
    chk("t_bus_err_tied", 32'(bus.bus_err), 0);
    bus.data_req = 0;
`endif
    reset = 0;
    #1;
    chk("t_rst_bus_err", 32'(bus.bus_err), 0);
    chk("t_rst_busy", 32'(bus.busy), 0);
    tick();
    reset = 1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
